// File: rtl/seq_booth_mul.sv
// seq_booth_mul: sequential radix-4 Booth multiplier, one Booth step per clock.
//
// Ports:
//   clock       - sole clock; all state updates on its rising edge
//   reset       - synchronous, active-high reset
//   start       - begin a multiply (sampled only while idle)
//   signed_mode - 1 = two's-complement operands, 0 = unsigned (captured with operands)
//   mcand       - multiplicand, N bits
//   mlier       - multiplier, N bits
//   busy        - high while a multiply is in progress (CALC and DONE)
//   valid       - single-cycle pulse marking a new result on product
//   product     - exact 2N-bit product, held until the next result or reset
//
// Latency: accept at edge E0, valid high in the cycle after edge E0+N/2+1.
// N must be even and >= 4.
module seq_booth_mul #(
   parameter int unsigned N = 16
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   input  logic           signed_mode,
   input  logic [N-1:0]   mcand,
   input  logic [N-1:0]   mlier,
   output logic           busy,
   output logic           valid,
   output logic [2*N-1:0] product
);

   localparam int unsigned CntW = $clog2(N / 2 + 1);
   localparam logic [CntW-1:0] LastStep = CntW'(N / 2);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

   state_t           state_q, state_d;
   // Multiplicand, pre-extended to 2N+2 bits and shifted left by 2 each step.
   logic [2*N+1:0]   mc_q, mc_d;
   // Multiplier extended to N+2 bits with the implicit y[-1]=0 appended;
   // bits [2:0] always hold the current Booth group.
   logic [N+2:0]     yb_q, yb_d;
   logic [2*N+1:0]   acc_q, acc_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0]   product_q, product_d;

   logic [2*N+1:0]   term;
   logic [2*N+1:0]   acc_sum;
   logic             sign_mc;
   logic             sign_ml;

   assign sign_mc = signed_mode & mcand[N-1];
   assign sign_ml = signed_mode & mlier[N-1];

   // Booth decode of the current group into 0, +-M, +-2M.
   always_comb begin
      term = '0;
      case (yb_q[2:0])
         3'b001, 3'b010: term = mc_q;
         3'b011:         term = mc_q << 1;
         3'b100:         term = -(mc_q << 1);
         3'b101, 3'b110: term = -mc_q;
         default:        term = '0;
      endcase
   end

   assign acc_sum = acc_q + term;

   always_comb begin
      state_d   = state_q;
      mc_d      = mc_q;
      yb_d      = yb_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               // The signed/unsigned choice is folded into the extensions here.
               mc_d    = {{(N + 2){sign_mc}}, mcand};
               yb_d    = {{2{sign_ml}}, mlier, 1'b0};
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            acc_d = acc_sum;
            mc_d  = mc_q << 2;
            yb_d  = yb_q >> 2;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastStep) begin
               // Final step: result goes straight to product, no extra cycle.
               product_d = acc_sum[2*N-1:0];
               state_d   = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         mc_q      <= '0;
         yb_q      <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mc_q      <= mc_d;
         yb_q      <= yb_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q != StIdle);
   assign valid   = (state_q == StDone);
   assign product = product_q;

endmodule

// File: tb/tb_seq_booth_mul.sv
// tb_seq_booth_mul: self-checking bench for seq_booth_mul at N=16.
// Reference model: plain 2N-bit multiply of sign- or zero-extended operands.
module tb_seq_booth_mul;

   localparam int unsigned N = 16;
   localparam int Lat  = N / 2 + 1;
   localparam int Intv = N / 2 + 3;

   logic           clock;
   logic           reset;
   logic           start;
   logic           signed_mode;
   logic [N-1:0]   mcand;
   logic [N-1:0]   mlier;
   logic           busy;
   logic           valid;
   logic [2*N-1:0] product;

   int total;
   int bad;

   seq_booth_mul #(.N(N)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .signed_mode (signed_mode),
      .mcand       (mcand),
      .mlier       (mlier),
      .busy        (busy),
      .valid       (valid),
      .product     (product)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [N-1:0] rnd();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[N-1:0];
   endfunction

   function automatic logic [2*N-1:0] ref_mul(logic [N-1:0] a, logic [N-1:0] b, logic sm);
      logic [2*N-1:0] ea;
      logic [2*N-1:0] eb;
      ea = sm ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
      eb = sm ? {{N{b[N-1]}}, b} : {{N{1'b0}}, b};
      return ea * eb;
   endfunction

   // Issues one multiply from a negedge, scrambles the inputs after the accept edge,
   // and reports what it observed. Returns at a negedge with the DUT idle.
   task automatic run_mul(input logic [N-1:0] a, input logic [N-1:0] b, input logic sm,
                          output logic [2*N-1:0] prod, output int lat, output int busy_n,
                          output logic busy_end, output logic valid_end);
      mcand = a; mlier = b; signed_mode = sm; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      mcand = rnd(); mlier = rnd(); signed_mode = 1'($urandom);
      busy_n = busy ? 1 : 0;
      lat = -1;
      prod = '0;
      for (int k = 1; k <= N + 8; k++) begin
         @(posedge clock);
         @(negedge clock);
         if (busy) busy_n++;
         if (valid) begin
            lat = k;
            prod = product;
            break;
         end
      end
      @(posedge clock);
      @(negedge clock);
      busy_end = busy;
      valid_end = valid;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; mcand = rnd(); mlier = rnd(); signed_mode = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      total++;
      if (busy !== 1'b0 || valid !== 1'b0 || product !== '0) begin
         bad++;
         $display("FAIL reset_state: busy=%b valid=%b product=%h, want 0 0 0", busy, valid,
                  product);
      end
      reset = 1'b0; start = 1'b0;
      @(posedge clock);
      @(negedge clock);
      total++;
      if (busy !== 1'b0 || valid !== 1'b0 || product !== '0) begin
         bad++;
         $display("FAIL idle_after_reset: busy=%b valid=%b product=%h", busy, valid, product);
      end
   endtask

   typedef struct {
      logic [N-1:0]   a;
      logic [N-1:0]   b;
      logic           sm;
      logic [2*N-1:0] exp;
   } vec_t;

   task automatic test_directed();
      vec_t v[8];
      logic [2*N-1:0] prod;
      int lat, bn;
      logic be, ve;
      v[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
      v[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
      v[2] = '{16'h8000, 16'h7FFF, 1'b1, 32'hC0008000};
      v[3] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
      v[4] = '{16'h0003, 16'h0005, 1'b0, 32'h0000000F};
      v[5] = '{16'h1234, 16'h0000, 1'b0, 32'h00000000};
      v[6] = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001};
      v[7] = '{16'h8000, 16'h8000, 1'b0, 32'h40000000};
      foreach (v[i]) begin
         run_mul(v[i].a, v[i].b, v[i].sm, prod, lat, bn, be, ve);
         total++;
         if (prod !== v[i].exp) begin
            bad++;
            $display("FAIL directed_product[%0d]: got %h want %h", i, prod, v[i].exp);
         end
         total++;
         if (lat != Lat) begin
            bad++;
            $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, Lat);
         end
         total++;
         if (bn != Lat + 1) begin
            bad++;
            $display("FAIL directed_busy_cycles[%0d]: got %0d want %0d", i, bn, Lat + 1);
         end
         total++;
         if (be !== 1'b0 || ve !== 1'b0) begin
            bad++;
            $display("FAIL directed_done_one_cycle[%0d]: busy=%b valid=%b want 0 0", i, be, ve);
         end
         // Idle with start low and noisy operands: product must hold.
         repeat (3) begin
            mcand = rnd(); mlier = rnd();
            @(posedge clock);
            @(negedge clock);
         end
         total++;
         if (product !== v[i].exp || busy !== 1'b0) begin
            bad++;
            $display("FAIL directed_hold[%0d]: product=%h busy=%b want %h 0", i, product, busy,
                     v[i].exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] qa[$];
      logic [N-1:0] qb[$];
      logic         qs[$];
      logic         exp_valid;
      logic         exp_busy;
      logic [2*N-1:0] exp_p;
      for (int e = 0; e <= 3 * Intv + Lat; e++) begin
         mcand = rnd(); mlier = rnd(); signed_mode = 1'($urandom); start = 1'b1;
         qa.push_back(mcand); qb.push_back(mlier); qs.push_back(signed_mode);
         @(posedge clock);
         @(negedge clock);
         exp_valid = (e >= Lat) && (((e - Lat) % Intv) == 0);
         exp_busy = ((e % Intv) != Intv - 1);
         total++;
         if (valid !== exp_valid || busy !== exp_busy) begin
            bad++;
            $display("FAIL b2b_flags[edge %0d]: valid=%b busy=%b want %b %b", e, valid, busy,
                     exp_valid, exp_busy);
         end
         if (exp_valid) begin
            exp_p = ref_mul(qa[e - Lat], qb[e - Lat], qs[e - Lat]);
            total++;
            if (product !== exp_p) begin
               bad++;
               $display("FAIL b2b_product[edge %0d]: got %h want %h", e, product, exp_p);
            end
         end
      end
      start = 1'b0;
      @(posedge clock);
      @(negedge clock);
      total++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_drain: busy=%b valid=%b want 0 0", busy, valid);
      end
   endtask

   task automatic test_reset_abort();
      logic [2*N-1:0] prod;
      logic [2*N-1:0] exp_p;
      logic [N-1:0] a, b;
      int lat, bn;
      logic be, ve;
      mcand = 16'h1234; mlier = 16'h5678; signed_mode = 1'b0; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (3) begin
         @(posedge clock);
         @(negedge clock);
         total++;
         if (valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_in_calc: valid=%b busy=%b want 0 1", valid, busy);
         end
      end
      reset = 1'b1; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0; start = 1'b0;
      total++;
      if (busy !== 1'b0 || valid !== 1'b0 || product !== '0) begin
         bad++;
         $display("FAIL abort_reset_state: busy=%b valid=%b product=%h want 0 0 0", busy, valid,
                  product);
      end
      a = rnd(); b = rnd();
      exp_p = ref_mul(a, b, 1'b1);
      run_mul(a, b, 1'b1, prod, lat, bn, be, ve);
      total++;
      if (prod !== exp_p || lat != Lat) begin
         bad++;
         $display("FAIL abort_restart: product=%h lat=%0d want %h %0d", prod, lat, exp_p, Lat);
      end
   endtask

   task automatic test_random();
      logic [2*N-1:0] prod;
      logic [2*N-1:0] exp_p;
      logic [N-1:0] a, b;
      logic sm;
      int lat, bn;
      logic be, ve;
      for (int i = 0; i < 2000; i++) begin
         a = rnd(); b = rnd(); sm = 1'($urandom);
         if (i % 16 == 0) a = {1'b1, {(N - 1){1'b0}}};
         if (i % 16 == 1) b = '1;
         exp_p = ref_mul(a, b, sm);
         run_mul(a, b, sm, prod, lat, bn, be, ve);
         total++;
         if (prod !== exp_p || lat != Lat || ve !== 1'b0) begin
            bad++;
            $display("FAIL random[%0d]: %h x %h sm=%b got %h lat=%0d want %h lat=%0d", i, a, b,
                     sm, prod, lat, exp_p, Lat);
         end
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset = 1'b1; start = 1'b0; signed_mode = 1'b0; mcand = '0; mlier = '0;
      @(negedge clock);
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
